// File: rtl/bus_cmd_master_if.sv
// Host-byte stream, response stream and strobed bus of the command master.
// The master modport is the parser side; slave is the UART/mcu_logic side.
interface bus_cmd_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baddr;
  logic [15:0] bwrdata;
  logic [15:0] brddata;
  logic        bwr;
  logic        bstrobe;

  modport master (
    input  rx_data, rx_valid, tx_ready, brddata,
    output rx_ready, tx_data, tx_valid, baddr, bwrdata, bwr, bstrobe
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, brddata,
    input  rx_ready, tx_data, tx_valid, baddr, bwrdata, bwr, bstrobe
  );
endinterface

// File: rtl/bus_cmd_master.sv
// Byte-stream command parser: 'W' aH aL dH dL writes, 'R' aH aL reads and
// returns the read word as two bytes. Drives one-cycle strobed bus cycles.
module bus_cmd_master #(
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_cmd_master_if.master      bus,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [1:0]      LAT      = 2'(RD_LATENCY);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]      CMD_W    = 8'h57;
  localparam logic [7:0]      CMD_R    = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
    S_BUS, S_WAIT_RD, S_TX_H, S_TX_L
  } state_t;

  state_t          r_state, w_nxt;
  logic [TW-1:0]   r_tmo;
  logic [1:0]      r_lat;
  logic            r_is_wr;
  logic [7:0]      r_addr_h, r_addr_l, r_data_h;
  logic [15:0]     r_rd;
  logic [15:0]     r_baddr, r_bwrdata;
  logic            r_bwr, r_bstrobe;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic [7:0]      r_err;

  logic            w_rx_ready, w_acc, w_parse;
  logic            w_bad, w_tmo, w_ovr, w_err, w_latch;
  logic [15:0]     w_rd;

  assign w_parse    = (r_state == S_ADDR_H) || (r_state == S_ADDR_L) ||
                      (r_state == S_DATA_H) || (r_state == S_DATA_L);
  assign w_rx_ready = (r_state == S_IDLE) || w_parse;
  assign w_acc      = bus.rx_valid && w_rx_ready;
  assign w_ovr      = bus.rx_valid && !w_rx_ready;
  assign w_tmo      = w_parse && !w_acc && (r_tmo == TMO_LAST);
  assign w_err      = w_ovr || w_bad || w_tmo;
  assign w_rd       = w_latch ? bus.brddata : r_rd;

  always_comb begin
    w_nxt   = r_state;
    w_bad   = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_acc) begin
          if (bus.rx_data == CMD_W || bus.rx_data == CMD_R) w_nxt = S_ADDR_H;
          else                                               w_bad = 1'b1;
        end
      S_ADDR_H:  if (w_acc) w_nxt = S_ADDR_L; else if (w_tmo) w_nxt = S_IDLE;
      S_ADDR_L:  if (w_acc) w_nxt = r_is_wr ? S_DATA_H : S_BUS;
                 else if (w_tmo) w_nxt = S_IDLE;
      S_DATA_H:  if (w_acc) w_nxt = S_DATA_L; else if (w_tmo) w_nxt = S_IDLE;
      S_DATA_L:  if (w_acc) w_nxt = S_BUS; else if (w_tmo) w_nxt = S_IDLE;
      S_BUS:
        if (r_is_wr)          w_nxt = S_IDLE;
        else if (LAT == 2'd0) begin w_nxt = S_TX_H; w_latch = 1'b1; end
        else                  w_nxt = S_WAIT_RD;
      S_WAIT_RD:
        if (r_lat == LAT) begin w_nxt = S_TX_H; w_latch = 1'b1; end
      S_TX_H:    if (bus.tx_ready) w_nxt = S_TX_L;
      S_TX_L:    if (bus.tx_ready) w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_lat      <= '0;
      r_is_wr    <= 1'b0;
      r_addr_h   <= '0;
      r_addr_l   <= '0;
      r_data_h   <= '0;
      r_rd       <= '0;
      r_baddr    <= '0;
      r_bwrdata  <= '0;
      r_bwr      <= 1'b0;
      r_bstrobe  <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state <= w_nxt;
      r_tmo   <= (w_parse && !w_acc && !w_tmo) ? r_tmo + 1'b1 : '0;

      if (w_acc) begin
        case (r_state)
          S_IDLE:   r_is_wr  <= (bus.rx_data == CMD_W);
          S_ADDR_H: r_addr_h <= bus.rx_data;
          S_ADDR_L: r_addr_l <= bus.rx_data;
          S_DATA_H: r_data_h <= bus.rx_data;
          default:  ;
        endcase
      end

      // Bus outputs load on the edge entering BUS so the strobe follows the
      // last command byte by exactly one clock; they then hold until the next.
      r_bstrobe <= (w_nxt == S_BUS);
      r_bwr     <= (w_nxt == S_BUS) && r_is_wr;
      if (w_nxt == S_BUS) begin
        r_baddr <= {r_addr_h, (r_state == S_ADDR_L) ? bus.rx_data : r_addr_l};
        if (r_is_wr) r_bwrdata <= {r_data_h, bus.rx_data};
      end

      if (r_state == S_BUS)          r_lat <= 2'd1;
      else if (r_state == S_WAIT_RD) r_lat <= r_lat + 2'd1;

      if (w_latch) r_rd <= bus.brddata;

      r_tx_valid <= (w_nxt == S_TX_H) || (w_nxt == S_TX_L);
      if (w_nxt == S_TX_H)      r_tx_data <= w_rd[15:8];
      else if (w_nxt == S_TX_L) r_tx_data <= w_rd[7:0];

      if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

  assign bus.rx_ready = w_rx_ready;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.baddr    = r_baddr;
  assign bus.bwrdata  = r_bwrdata;
  assign bus.bwr      = r_bwr;
  assign bus.bstrobe  = r_bstrobe;
  assign busy         = (r_state != S_IDLE);
  assign err_count    = r_err;

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master: write, read, backpressure, bad bytes,
// inter-byte timeout and mid-command reset, with hand-computed expectations.
module tb_bus_cmd_master;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [7:0] err_count;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_strobe = 0;
  int         n_tx = 0;
  int         s0, t0;

  bus_cmd_master_if bif();

  bus_cmd_master #(.RD_LATENCY(1), .TIMEOUT(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .busy      (busy),
    .err_count (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bif.bstrobe) n_strobe++;
    if (bif.tx_valid && bif.tx_ready) n_tx++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    cyc();
    bif.rx_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    bif.tx_ready = 1'b1;
    bif.brddata  = 16'hBEEF;
    repeat (3) cyc();
    check("rst_bstrobe", bif.bstrobe, 0);
    check("rst_bwr", bif.bwr, 0);
    check("rst_baddr", bif.baddr, 0);
    check("rst_bwrdata", bif.bwrdata, 0);
    check("rst_tx_valid", bif.tx_valid, 0);
    check("rst_tx_data", bif.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    check("rst_rx_ready", bif.rx_ready, 1);
    rst = 1'b0;
    cyc();

    // write 57 12 34 AB CD
    s0 = n_strobe; t0 = n_tx;
    send(8'h57); send(8'h12); send(8'h34); send(8'hAB);
    check("wr_no_early_strobe", bif.bstrobe, 0);
    send(8'hCD);
    check("wr_bstrobe", bif.bstrobe, 1);
    check("wr_bwr", bif.bwr, 1);
    check("wr_baddr", bif.baddr, 32'h1234);
    check("wr_bwrdata", bif.bwrdata, 32'hABCD);
    check("wr_rx_ready_bus", bif.rx_ready, 0);
    cyc();
    check("wr_strobe_drop", bif.bstrobe, 0);
    check("wr_bwr_drop", bif.bwr, 0);
    check("wr_busy_done", busy, 0);
    check("wr_baddr_hold", bif.baddr, 32'h1234);
    repeat (3) cyc();
    check("wr_one_strobe", n_strobe - s0, 1);
    check("wr_no_tx", n_tx - t0, 0);

    // read 52 00 05, data presented only in the latency-1 sample cycle
    s0 = n_strobe; t0 = n_tx;
    bif.brddata = 16'h1111;
    send(8'h52); send(8'h00); send(8'h05);
    check("rd_bstrobe", bif.bstrobe, 1);
    check("rd_bwr", bif.bwr, 0);
    check("rd_baddr", bif.baddr, 32'h0005);
    cyc();
    bif.brddata = 16'hBEEF;
    check("rd_wait_no_tx", bif.tx_valid, 0);
    cyc();
    bif.brddata = 16'h2222;
    check("rd_tx_valid_h", bif.tx_valid, 1);
    check("rd_tx_h", bif.tx_data, 32'hBE);
    cyc();
    check("rd_tx_l", bif.tx_data, 32'hEF);
    check("rd_busy_l", busy, 1);
    cyc();
    check("rd_tx_valid_end", bif.tx_valid, 0);
    check("rd_busy_end", busy, 0);
    check("rd_one_strobe", n_strobe - s0, 1);
    check("rd_two_tx", n_tx - t0, 2);

    // backpressure and overrun
    bif.tx_ready = 1'b0;
    bif.brddata  = 16'hC0DE;
    send(8'h52); send(8'h00); send(8'h07);
    cyc(); cyc();
    s0 = err_count;
    for (int i = 0; i < 20; i++) begin
      if (i < 3) begin
        bif.rx_valid = 1'b1;
        bif.rx_data  = 8'h57;
      end
      check("bp_rx_ready", bif.rx_ready, 0);
      cyc();
      bif.rx_valid = 1'b0;
      check("bp_tx_valid", bif.tx_valid, 1);
      check("bp_tx_data", bif.tx_data, 32'hC0);
    end
    check("bp_overrun_err", err_count, s0 + 3);
    bif.tx_ready = 1'b1;
    cyc();
    check("bp_tx_l", bif.tx_data, 32'hDE);
    cyc();
    check("bp_done", busy, 0);

    // bad command bytes from a clean error count
    rst = 1'b1; cyc(); rst = 1'b0;
    s0 = n_strobe;
    send(8'h00); send(8'hFF);
    check("bad_err", err_count, 2);
    check("bad_busy", busy, 0);
    send(8'h57); send(8'h0A); send(8'hBC); send(8'h55); send(8'hAA);
    check("bad_then_wr_strobe", bif.bstrobe, 1);
    check("bad_then_wr_bwr", bif.bwr, 1);
    check("bad_then_wr_addr", bif.baddr, 32'h0ABC);
    check("bad_then_wr_data", bif.bwrdata, 32'h55AA);
    cyc();
    check("bad_strobes", n_strobe - s0, 1);

    // inter-byte timeout
    s0 = n_strobe;
    send(8'h57); send(8'h12);
    repeat (49) cyc();
    check("tmo_busy_49", busy, 1);
    check("tmo_err_49", err_count, 2);
    cyc();
    check("tmo_busy_50", busy, 0);
    check("tmo_err_50", err_count, 3);
    repeat (10) cyc();
    check("tmo_no_strobe", n_strobe - s0, 0);
    bif.brddata = 16'h1357;
    send(8'h52); send(8'h00); send(8'h05);
    check("tmo_rd_strobe", bif.bstrobe, 1);
    check("tmo_rd_bwr", bif.bwr, 0);
    check("tmo_rd_addr", bif.baddr, 32'h0005);
    cyc(); cyc();
    check("tmo_rd_tx_h", bif.tx_data, 32'h13);
    cyc();
    check("tmo_rd_tx_l", bif.tx_data, 32'h57);
    cyc();
    check("tmo_rd_end", busy, 0);

    // reset during DATA_L, with the final byte arriving under reset
    s0 = n_strobe;
    send(8'h57); send(8'h11); send(8'h22); send(8'h33);
    check("rstd_busy_pre", busy, 1);
    rst = 1'b1;
    bif.rx_valid = 1'b1;
    bif.rx_data  = 8'h44;
    cyc();
    bif.rx_valid = 1'b0;
    rst = 1'b0;
    check("rstd_busy", busy, 0);
    check("rstd_bstrobe", bif.bstrobe, 0);
    check("rstd_baddr", bif.baddr, 0);
    check("rstd_bwrdata", bif.bwrdata, 0);
    check("rstd_err", err_count, 0);
    repeat (4) cyc();
    check("rstd_no_strobe", n_strobe - s0, 0);

    // reset during TX_H
    bif.tx_ready = 1'b0;
    bif.brddata  = 16'h4242;
    send(8'h52); send(8'h00); send(8'h09);
    cyc(); cyc();
    check("rstt_tx_valid_pre", bif.tx_valid, 1);
    t0 = n_tx;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rstt_tx_valid", bif.tx_valid, 0);
    check("rstt_tx_data", bif.tx_data, 0);
    check("rstt_busy", busy, 0);
    bif.tx_ready = 1'b1;
    repeat (5) cyc();
    check("rstt_no_tx", n_tx - t0, 0);
    check("rstt_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
